// File: rtl/ctrl_datapath_if.sv
// Control/data bus between the sequencing FSM (or a host) and the execution datapath.
// The master drives the control word, operands and preload port; the slave returns flags.
interface ctrl_datapath_if #(
  parameter int unsigned W = 8
);
  logic [14:0]  i_signal;
  logic [W-1:0] i_data;
  logic         i_load;
  logic [3:0]   i_load_addr;
  logic [W-1:0] i_load_data;
  logic         o_mayor;
  logic         o_zero;
  logic         o_carry;
  logic [W-1:0] o_result;
  logic [W-1:0] o_rd_data;

  modport master (
    output i_signal, i_data, i_load, i_load_addr, i_load_data,
    input  o_mayor, o_zero, o_carry, o_result, o_rd_data
  );

  modport slave (
    input  i_signal, i_data, i_load, i_load_addr, i_load_data,
    output o_mayor, o_zero, o_carry, o_result, o_rd_data
  );
endinterface

// File: rtl/ctrl_datapath.sv
// Execution datapath: register bank, A/B operand muxes, 4-function ALU and registered flags.
// Driven every cycle by a 15-bit control word; external preload port seeds and reads the bank.
module ctrl_datapath #(
  parameter int unsigned W    = 8,
  parameter int unsigned NREG = 15
) (
  input logic            clk,
  input logic            rst,
  ctrl_datapath_if.slave bus
);

  localparam logic [4:0] NregL = 5'(NREG);

  logic [1:0]   alu_op;
  logic [3:0]   sel_a, sel_b, sel_reg;
  logic         wr_en;
  logic [W-1:0] op_a, op_b;
  logic [W:0]   alu_ext;
  logic [W-1:0] rd_data;

  logic [W-1:0] regs_q [NREG];
  logic [W-1:0] regs_d [NREG];
  logic         mayor_q, mayor_d;
  logic         zero_q, zero_d;
  logic         carry_q, carry_d;
  logic [W-1:0] result_q, result_d;

  assign alu_op  = bus.i_signal[14:13];
  assign sel_a   = bus.i_signal[12:9];
  assign sel_b   = bus.i_signal[8:5];
  assign sel_reg = bus.i_signal[4:1];
  assign wr_en   = bus.i_signal[0];

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (sel_a == 4'hF) begin
      op_a = bus.i_data;
    end else if ({1'b0, sel_a} < NregL) begin
      op_a = regs_q[sel_a];
    end
    if (sel_b == 4'hF) begin
      op_b = bus.i_data;
    end else if ({1'b0, sel_b} < NregL) begin
      op_b = regs_q[sel_b];
    end
  end

  // Top bit is carry for add, borrow for sub, and always 0 for pass/and.
  always_comb begin
    alu_ext = '0;
    unique case (alu_op)
      2'b00:   alu_ext = {1'b0, op_a};
      2'b01:   alu_ext = {1'b0, op_a} + {1'b0, op_b};
      2'b10:   alu_ext = {1'b0, op_a} - {1'b0, op_b};
      default: alu_ext = {1'b0, op_a & op_b};
    endcase
  end

  always_comb begin
    result_d = alu_ext[W-1:0];
    zero_d   = (alu_ext[W-1:0] == '0);
    carry_d  = alu_ext[W];
    mayor_d  = (op_a > op_b);
  end

  // External load is applied last so it wins over a control write to the same register.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && ({1'b0, sel_reg} < NregL)) begin
      regs_d[sel_reg] = alu_ext[W-1:0];
    end
    if (bus.i_load && ({1'b0, bus.i_load_addr} < NregL)) begin
      regs_d[bus.i_load_addr] = bus.i_load_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, bus.i_load_addr} < NregL) begin
      rd_data = regs_q[bus.i_load_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
      mayor_q  <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
    end else begin
      regs_q   <= regs_d;
      mayor_q  <= mayor_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      result_q <= result_d;
    end
  end

  assign bus.o_mayor   = mayor_q;
  assign bus.o_zero    = zero_q;
  assign bus.o_carry   = carry_q;
  assign bus.o_result  = result_q;
  assign bus.o_rd_data = rd_data;

endmodule

// File: tb/tb_ctrl_datapath.sv
// Bench for ctrl_datapath: directed scenarios plus random control words,
// all checked against an array-based behavioural model of the register bank and ALU.
module tb_ctrl_datapath;

  localparam int unsigned W = 8;
  localparam int NREG = 15;

  logic clk;
  logic rst;

  ctrl_datapath_if #(.W(W)) bus ();

  ctrl_datapath #(.W(W), .NREG(NREG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int mdl [NREG];
  int exp_result, exp_zero, exp_carry, exp_mayor;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [14:0] mkw(input int op, input int a, input int b, input int r,
                                      input int w);
    logic [14:0] word;
    word[14:13] = 2'(op);
    word[12:9]  = 4'(a);
    word[8:5]   = 4'(b);
    word[4:1]   = 4'(r);
    word[0]     = 1'(w);
    return word;
  endfunction

  function automatic int operand(input int sel, input int data);
    if (sel == 15) return data;
    if (sel < NREG) return mdl[sel];
    return 0;
  endfunction

  // One clock: apply inputs, predict from the model, check every output after the edge.
  task automatic step(input logic [14:0] word, input int data, input int load,
                      input int laddr, input int ldata);
    int op, a, b, r, w, res;
    op = int'(word[14:13]);
    a  = operand(int'(word[12:9]), data);
    b  = operand(int'(word[8:5]), data);
    r  = int'(word[4:1]);
    w  = int'(word[0]);
    bus.i_signal    = word;
    bus.i_data      = W'(data);
    bus.i_load      = 1'(load);
    bus.i_load_addr = 4'(laddr);
    bus.i_load_data = W'(ldata);
    case (op)
      0: begin res = a; exp_carry = 0; end
      1: begin res = (a + b) % 256; exp_carry = (a + b > 255) ? 1 : 0; end
      2: begin res = (a - b + 256) % 256; exp_carry = (a < b) ? 1 : 0; end
      default: begin res = a & b; exp_carry = 0; end
    endcase
    exp_result = res;
    exp_zero   = (res == 0) ? 1 : 0;
    exp_mayor  = (a > b) ? 1 : 0;
    @(posedge clk);
    #1;
    if (w == 1 && r < NREG) mdl[r] = res;
    if (load == 1 && laddr < NREG) mdl[laddr] = ldata;
    check("result", 32'(bus.o_result), 32'(exp_result));
    check("zero",   32'(bus.o_zero),   32'(exp_zero));
    check("carry",  32'(bus.o_carry),  32'(exp_carry));
    check("mayor",  32'(bus.o_mayor),  32'(exp_mayor));
    check("rd_data", 32'(bus.o_rd_data), (laddr < NREG) ? 32'(mdl[laddr]) : 32'd0);
  endtask

  task automatic peek(input int addr, input int exp);
    bus.i_load      = 1'b0;
    bus.i_load_addr = 4'(addr);
    #1;
    check("peek", 32'(bus.o_rd_data), 32'(exp));
  endtask

  task automatic load(input int addr, input int val);
    step(15'd0, 0, 1, addr, val);
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) mdl[i] = 0;
    rst = 1'b1;
    bus.i_signal = '0; bus.i_data = '0; bus.i_load = 1'b0;
    bus.i_load_addr = '0; bus.i_load_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", 32'(bus.o_result), 32'd0);
    check("rst_mayor",  32'(bus.o_mayor),  32'd0);
    check("rst_zero",   32'(bus.o_zero),   32'd0);
    check("rst_carry",  32'(bus.o_carry),  32'd0);
    rst = 1'b0;

    // Basic add with write-back
    load(1, 5);
    load(2, 3);
    step(mkw(1, 1, 2, 4, 1), 0, 0, 4, 0);
    check("add_res8", 32'(bus.o_result), 32'd8);
    check("add_r4",   32'(bus.o_rd_data), 32'd8);

    // Wrap-around carry, then sub with borrow
    load(1, 8'hFF);
    load(2, 8'h01);
    step(mkw(1, 1, 2, 0, 0), 0, 0, 0, 0);
    check("wrap_zero", 32'(bus.o_zero), 32'd1);
    step(mkw(2, 2, 1, 0, 0), 0, 0, 0, 0);
    check("sub_res2", 32'(bus.o_result), 32'd2);
    check("sub_borrow", 32'(bus.o_carry), 32'd1);

    // Simultaneous writes: same register, then different registers
    step(mkw(1, 1, 2, 4, 1), 0, 1, 4, 8'h11);
    peek(4, 8'h11);
    step(mkw(3, 1, 2, 5, 1), 0, 1, 4, 8'h11);
    peek(4, 8'h11);
    peek(5, 8'h01);

    // External operand and write to reserved index
    load(0, 0);
    step(mkw(0, 15, 0, 15, 1), 8'h7A, 0, 0, 0);
    check("ext_res", 32'(bus.o_result), 32'h7A);
    for (int i = 0; i < NREG; i++) peek(i, mdl[i]);

    // Held compare, then operand change shows one cycle later
    load(1, 9);
    load(2, 9);
    step(mkw(2, 1, 2, 0, 0), 0, 0, 0, 0);
    step(mkw(2, 1, 2, 0, 0), 0, 1, 1, 10);
    check("cmp_eq", 32'(bus.o_mayor), 32'd0);
    step(mkw(2, 1, 2, 0, 0), 0, 0, 0, 0);
    check("cmp_gt", 32'(bus.o_mayor), 32'd1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(15'($urandom), int'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0) ? 1 : 0,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
    end

    // Asynchronous reset mid-cycle
    load(3, 8'h55);
    step(mkw(0, 3, 0, 0, 0), 0, 0, 3, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_r3",     32'(bus.o_rd_data), 32'd0);
    check("arst_mayor",  32'(bus.o_mayor),   32'd0);
    check("arst_result", 32'(bus.o_result),  32'd0);
    for (int i = 0; i < NREG; i++) mdl[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) peek(i, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
